// File: rtl/tanimoto_job_ctrl_pkg.sv
// rtl/tanimoto_job_ctrl_pkg.sv - shared state encoding, descriptor layout and beat math
package tanimoto_job_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_CMP,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    // Descriptor layout: comparison count C in the low field, total count N above it
    localparam int JOB_C_LSB = 0;

    function automatic int job_n_lsb(input int vec_id_width);
        return vec_id_width;
    endfunction

    function automatic int beats_per_vec(input int vector_width, input int bus_width);
        return (vector_width + bus_width - 1) / bus_width;
    endfunction

endpackage

// File: rtl/tanimoto_job_cnt.sv
// rtl/tanimoto_job_cnt.sv - clearable up-counter with terminal compare and optional saturation
module tanimoto_job_cnt #(
    parameter int WIDTH    = 10,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic [WIDTH-1:0] term,
    output logic [WIDTH-1:0] count,
    output logic             at_term
);

    assign at_term = (count == term);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !(SATURATE && (&count))) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/tanimoto_job_ctrl.sv
// rtl/tanimoto_job_ctrl.sv - one-job-at-a-time sequencer around the Tanimoto pipeline
module tanimoto_job_ctrl
    import tanimoto_job_ctrl_pkg::*;
#(
    parameter int BUS_WIDTH      = 512,
    parameter int VECTOR_WIDTH   = 920,
    parameter int VEC_ID_WIDTH   = 8,
    parameter int PAIR_CNT_WIDTH = 16
) (
    input  logic                        ap_clk,
    input  logic                        ap_rstn,

    input  logic [2*VEC_ID_WIDTH-1:0]   S_AXIS_JOB_tdata,
    input  logic                        S_AXIS_JOB_tvalid,
    output logic                        S_AXIS_JOB_tready,

    output logic [VEC_ID_WIDTH-1:0]     M_AXIS_CMP_VEC_NO_tdata,
    output logic                        M_AXIS_CMP_VEC_NO_tvalid,
    input  logic                        M_AXIS_CMP_VEC_NO_tready,

    input  logic [BUS_WIDTH-1:0]        S_AXIS_SRC_tdata,
    input  logic                        S_AXIS_SRC_tvalid,
    output logic                        S_AXIS_SRC_tready,

    output logic [BUS_WIDTH-1:0]        M_AXIS_DATA_tdata,
    output logic                        M_AXIS_DATA_tvalid,
    input  logic                        M_AXIS_DATA_tready,

    input  logic [2*VEC_ID_WIDTH-1:0]   S_AXIS_PAIR_tdata,
    input  logic                        S_AXIS_PAIR_tvalid,
    input  logic                        S_AXIS_PAIR_tlast,
    output logic                        S_AXIS_PAIR_tready,

    output logic [2*VEC_ID_WIDTH-1:0]   M_AXIS_RES_tdata,
    output logic                        M_AXIS_RES_tvalid,
    output logic                        M_AXIS_RES_tlast,
    input  logic                        M_AXIS_RES_tready,

    output logic                        o_Busy,
    output logic                        o_Done,
    output logic                        o_Error,
    output logic [PAIR_CNT_WIDTH-1:0]   o_PairCount
);

    localparam int BEATS_PER_VEC = beats_per_vec(VECTOR_WIDTH, BUS_WIDTH);
    localparam int CW            = VEC_ID_WIDTH + $clog2(BEATS_PER_VEC) + 1;
    localparam int N_LSB         = job_n_lsb(VEC_ID_WIDTH);

    state_t                   state;
    logic                     job_ready;
    logic                     cmp_valid;
    logic [VEC_ID_WIDTH-1:0]  cmp_data;
    logic                     data_en;
    logic                     pair_en;
    logic                     busy;
    logic                     done;
    logic                     error;
    logic                     last_seen;
    logic [CW-1:0]            beat_total;
    logic [CW-1:0]            beat_count_unused;
    logic                     beat_at_term;
    logic                     pair_at_max;

    logic [VEC_ID_WIDTH-1:0]  job_n;
    logic [VEC_ID_WIDTH-1:0]  job_c;
    logic                     job_hs;
    logic                     job_bad;
    logic                     cmp_hs;
    logic                     data_hs;
    logic                     pair_hs;

    assign job_n   = S_AXIS_JOB_tdata[N_LSB +: VEC_ID_WIDTH];
    assign job_c   = S_AXIS_JOB_tdata[JOB_C_LSB +: VEC_ID_WIDTH];
    assign job_hs  = job_ready && S_AXIS_JOB_tvalid;
    assign job_bad = (job_n == '0) || (job_c == '0) || (job_c > job_n);
    assign cmp_hs  = cmp_valid && M_AXIS_CMP_VEC_NO_tready;
    assign data_hs = data_en && S_AXIS_SRC_tvalid && M_AXIS_DATA_tready;
    assign pair_hs = pair_en && S_AXIS_PAIR_tvalid && M_AXIS_RES_tready;

    // Gates come from registered enables; payloads pass straight through
    assign S_AXIS_JOB_tready        = job_ready;
    assign M_AXIS_CMP_VEC_NO_tvalid = cmp_valid;
    assign M_AXIS_CMP_VEC_NO_tdata  = cmp_data;
    assign M_AXIS_DATA_tdata        = S_AXIS_SRC_tdata;
    assign M_AXIS_DATA_tvalid       = data_en && S_AXIS_SRC_tvalid;
    assign S_AXIS_SRC_tready        = data_en && M_AXIS_DATA_tready;
    assign M_AXIS_RES_tdata         = S_AXIS_PAIR_tdata;
    assign M_AXIS_RES_tlast         = S_AXIS_PAIR_tlast;
    assign M_AXIS_RES_tvalid        = pair_en && S_AXIS_PAIR_tvalid;
    assign S_AXIS_PAIR_tready       = pair_en && M_AXIS_RES_tready;
    assign o_Busy                   = busy;
    assign o_Done                   = done;
    assign o_Error                  = error;

    tanimoto_job_cnt #(
        .WIDTH    (CW),
        .SATURATE (1'b0)
    ) u_beat_cnt (
        .clk     (ap_clk),
        .rst_n   (ap_rstn),
        .clr     (job_hs),
        .inc     (data_hs),
        .term    (beat_total - CW'(1)),
        .count   (beat_count_unused),
        .at_term (beat_at_term)
    );

    tanimoto_job_cnt #(
        .WIDTH    (PAIR_CNT_WIDTH),
        .SATURATE (1'b1)
    ) u_pair_cnt (
        .clk     (ap_clk),
        .rst_n   (ap_rstn),
        .clr     (job_hs),
        .inc     (pair_hs && !pair_at_max),
        .term    ('1),
        .count   (o_PairCount),
        .at_term (pair_at_max)
    );

    always_ff @(posedge ap_clk or negedge ap_rstn) begin
        if (!ap_rstn) begin
            state      <= IDLE;
            job_ready  <= 1'b1;
            cmp_valid  <= 1'b0;
            cmp_data   <= '0;
            data_en    <= 1'b0;
            pair_en    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            last_seen  <= 1'b0;
            beat_total <= '0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    if (job_hs) begin
                        cmp_data   <= job_c;
                        beat_total <= CW'(job_n) * CW'(BEATS_PER_VEC);
                        last_seen  <= 1'b0;
                        busy       <= 1'b1;
                        job_ready  <= 1'b0;
                        if (job_bad) begin
                            done  <= 1'b1;
                            error <= 1'b1;
                            state <= DONE;
                        end else begin
                            cmp_valid <= 1'b1;
                            state     <= LOAD_CMP;
                        end
                    end
                end
                LOAD_CMP: begin
                    if (cmp_hs) begin
                        cmp_valid <= 1'b0;
                        data_en   <= 1'b1;
                        pair_en   <= 1'b1;
                        state     <= STREAM;
                    end
                end
                STREAM: begin
                    if (pair_hs && S_AXIS_PAIR_tlast) begin
                        last_seen <= 1'b1;
                    end
                    if (data_hs && beat_at_term) begin
                        data_en <= 1'b0;
                        state   <= DRAIN;
                    end
                end
                DRAIN: begin
                    // A tlast may have arrived while data was still streaming
                    if (last_seen || (pair_hs && S_AXIS_PAIR_tlast)) begin
                        last_seen <= 1'b1;
                        pair_en   <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    busy      <= 1'b0;
                    job_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tanimoto_job_ctrl.sv
// tb/tb_tanimoto_job_ctrl.sv - scoreboard bench for tanimoto_job_ctrl
module tb_tanimoto_job_ctrl;

    localparam int BW = 512;
    localparam int V  = 8;
    localparam int PW = 16;

    logic            ap_clk = 1'b0;
    logic            ap_rstn = 1'b0;
    logic [2*V-1:0]  S_AXIS_JOB_tdata = '0;
    logic            S_AXIS_JOB_tvalid = 1'b0;
    logic            S_AXIS_JOB_tready;
    logic [V-1:0]    M_AXIS_CMP_VEC_NO_tdata;
    logic            M_AXIS_CMP_VEC_NO_tvalid;
    logic            M_AXIS_CMP_VEC_NO_tready = 1'b1;
    logic [BW-1:0]   S_AXIS_SRC_tdata = '0;
    logic            S_AXIS_SRC_tvalid = 1'b0;
    logic            S_AXIS_SRC_tready;
    logic [BW-1:0]   M_AXIS_DATA_tdata;
    logic            M_AXIS_DATA_tvalid;
    logic            M_AXIS_DATA_tready = 1'b1;
    logic [2*V-1:0]  S_AXIS_PAIR_tdata = '0;
    logic            S_AXIS_PAIR_tvalid = 1'b0;
    logic            S_AXIS_PAIR_tlast = 1'b0;
    logic            S_AXIS_PAIR_tready;
    logic [2*V-1:0]  M_AXIS_RES_tdata;
    logic            M_AXIS_RES_tvalid;
    logic            M_AXIS_RES_tlast;
    logic            M_AXIS_RES_tready = 1'b1;
    logic            o_Busy;
    logic            o_Done;
    logic            o_Error;
    logic [PW-1:0]   o_PairCount;

    always #5 ap_clk = ~ap_clk;

    tanimoto_job_ctrl dut (
        .ap_clk                   (ap_clk),
        .ap_rstn                  (ap_rstn),
        .S_AXIS_JOB_tdata         (S_AXIS_JOB_tdata),
        .S_AXIS_JOB_tvalid        (S_AXIS_JOB_tvalid),
        .S_AXIS_JOB_tready        (S_AXIS_JOB_tready),
        .M_AXIS_CMP_VEC_NO_tdata  (M_AXIS_CMP_VEC_NO_tdata),
        .M_AXIS_CMP_VEC_NO_tvalid (M_AXIS_CMP_VEC_NO_tvalid),
        .M_AXIS_CMP_VEC_NO_tready (M_AXIS_CMP_VEC_NO_tready),
        .S_AXIS_SRC_tdata         (S_AXIS_SRC_tdata),
        .S_AXIS_SRC_tvalid        (S_AXIS_SRC_tvalid),
        .S_AXIS_SRC_tready        (S_AXIS_SRC_tready),
        .M_AXIS_DATA_tdata        (M_AXIS_DATA_tdata),
        .M_AXIS_DATA_tvalid       (M_AXIS_DATA_tvalid),
        .M_AXIS_DATA_tready       (M_AXIS_DATA_tready),
        .S_AXIS_PAIR_tdata        (S_AXIS_PAIR_tdata),
        .S_AXIS_PAIR_tvalid       (S_AXIS_PAIR_tvalid),
        .S_AXIS_PAIR_tlast        (S_AXIS_PAIR_tlast),
        .S_AXIS_PAIR_tready       (S_AXIS_PAIR_tready),
        .M_AXIS_RES_tdata         (M_AXIS_RES_tdata),
        .M_AXIS_RES_tvalid        (M_AXIS_RES_tvalid),
        .M_AXIS_RES_tlast         (M_AXIS_RES_tlast),
        .M_AXIS_RES_tready        (M_AXIS_RES_tready),
        .o_Busy                   (o_Busy),
        .o_Done                   (o_Done),
        .o_Error                  (o_Error),
        .o_PairCount              (o_PairCount)
    );

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    logic [BW-1:0] src_q[$];
    logic [BW-1:0] exp_data[$];
    logic [2*V:0]  pair_q[$];
    logic [2*V:0]  exp_res[$];
    logic [V-1:0]  exp_cmp[$];

    int beat_cnt = 0, cmp_hs_cnt = 0, done_cnt = 0, err_cnt = 0;
    int last_beat_cyc = 0, last_pair_cyc = 0, done_cyc = 0, acc_cyc = 0;
    bit cmp_hold = 1'b0;
    logic [V-1:0] cmp_prev = '0;
    bit bp = 1'b0;

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(posedge ap_clk) cyc <= cyc + 1;

    // Drivers: present queue heads and random readies just after each rising edge
    initial begin
        forever begin
            @(posedge ap_clk);
            #1;
            S_AXIS_SRC_tvalid = (src_q.size() != 0);
            S_AXIS_SRC_tdata  = (src_q.size() != 0) ? src_q[0] : '0;
            S_AXIS_PAIR_tvalid = (pair_q.size() != 0);
            {S_AXIS_PAIR_tlast, S_AXIS_PAIR_tdata} = (pair_q.size() != 0) ? pair_q[0] : '0;
            M_AXIS_DATA_tready       = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            M_AXIS_CMP_VEC_NO_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            M_AXIS_RES_tready        = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: handshakes observed mid-cycle, scoreboard compare on every output beat
    initial begin
        forever begin
            @(negedge ap_clk);
            if (!ap_rstn) begin
                cmp_hold = 1'b0;
            end else begin
                if (S_AXIS_SRC_tvalid && S_AXIS_SRC_tready && src_q.size() != 0) src_q.delete(0);
                if (S_AXIS_PAIR_tvalid && S_AXIS_PAIR_tready && pair_q.size() != 0) pair_q.delete(0);
                if (M_AXIS_DATA_tvalid && M_AXIS_DATA_tready) begin
                    beat_cnt++;
                    last_beat_cyc = cyc;
                    check("data_expected", BW'(exp_data.size() != 0), BW'(1));
                    if (exp_data.size() != 0) check("data", M_AXIS_DATA_tdata, exp_data.pop_front());
                end
                if (M_AXIS_CMP_VEC_NO_tvalid) begin
                    if (cmp_hold) check("cmp_stable", BW'(M_AXIS_CMP_VEC_NO_tdata), BW'(cmp_prev));
                    if (M_AXIS_CMP_VEC_NO_tready) begin
                        cmp_hs_cnt++;
                        cmp_hold = 1'b0;
                        check("cmp_expected", BW'(exp_cmp.size() != 0), BW'(1));
                        if (exp_cmp.size() != 0) check("cmp_data", BW'(M_AXIS_CMP_VEC_NO_tdata), BW'(exp_cmp.pop_front()));
                    end else begin
                        cmp_hold = 1'b1;
                        cmp_prev = M_AXIS_CMP_VEC_NO_tdata;
                    end
                end else begin
                    cmp_hold = 1'b0;
                end
                if (M_AXIS_RES_tvalid && M_AXIS_RES_tready) begin
                    if (M_AXIS_RES_tlast) last_pair_cyc = cyc;
                    check("res_expected", BW'(exp_res.size() != 0), BW'(1));
                    if (exp_res.size() != 0) check("res", BW'({M_AXIS_RES_tlast, M_AXIS_RES_tdata}), BW'(exp_res.pop_front()));
                end
                if (o_Done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    if (o_Error) err_cnt++;
                end
            end
        end
    end

    function automatic logic [BW-1:0] rand_beat();
        logic [BW-1:0] b;
        for (int i = 0; i < BW / 32; i++) b[i*32 +: 32] = $urandom();
        return b;
    endfunction

    task automatic load_beats(input int n_push, input int n_exp);
        logic [BW-1:0] b;
        for (int i = 0; i < n_push; i++) begin
            b = rand_beat();
            src_q.push_back(b);
            if (i < n_exp) exp_data.push_back(b);
        end
    endtask

    task automatic push_pairs(input int n);
        logic [2*V:0] p;
        for (int i = 0; i < n; i++) begin
            p = {(i == n - 1), 16'($urandom())};
            pair_q.push_back(p);
            exp_res.push_back(p);
        end
    endtask

    task automatic send_job(input int n, input int c);
        int t = 0;
        @(posedge ap_clk);
        #1;
        S_AXIS_JOB_tdata  = {V'(n), V'(c)};
        S_AXIS_JOB_tvalid = 1'b1;
        @(negedge ap_clk);
        while (!S_AXIS_JOB_tready && t < 50) begin
            @(negedge ap_clk);
            t++;
        end
        check("job_accept", BW'(S_AXIS_JOB_tready), BW'(1));
        acc_cyc = cyc;
        @(posedge ap_clk);
        #1;
        S_AXIS_JOB_tvalid = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget);
        int t = 0;
        while (beat_cnt < n && t < budget) begin
            @(negedge ap_clk);
            t++;
        end
        check("beats_in_time", BW'(beat_cnt >= n), BW'(1));
    endtask

    task automatic wait_done(input int prev, input int budget);
        int t = 0;
        while (done_cnt <= prev && t < budget) begin
            @(negedge ap_clk);
            t++;
        end
        check("done_in_time", BW'(done_cnt > prev), BW'(1));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_job_tready"}, BW'(S_AXIS_JOB_tready), BW'(1));
        check({tag, "_cmp_tvalid"}, BW'(M_AXIS_CMP_VEC_NO_tvalid), BW'(0));
        check({tag, "_cmp_tdata"}, BW'(M_AXIS_CMP_VEC_NO_tdata), BW'(0));
        check({tag, "_src_tready"}, BW'(S_AXIS_SRC_tready), BW'(0));
        check({tag, "_data_tvalid"}, BW'(M_AXIS_DATA_tvalid), BW'(0));
        check({tag, "_pair_tready"}, BW'(S_AXIS_PAIR_tready), BW'(0));
        check({tag, "_res_tvalid"}, BW'(M_AXIS_RES_tvalid), BW'(0));
        check({tag, "_busy"}, BW'(o_Busy), BW'(0));
        check({tag, "_done"}, BW'(o_Done), BW'(0));
        check({tag, "_error"}, BW'(o_Error), BW'(0));
        check({tag, "_pair_count"}, BW'(o_PairCount), BW'(0));
    endtask

    initial begin
        int d, e, h;
        int rej_n[2] = '{3, 0};
        int rej_c[2] = '{5, 1};

        repeat (2) @(negedge ap_clk);
        check_idle_outputs("reset");
        @(posedge ap_clk);
        #1;
        ap_rstn = 1'b1;

        // Nominal N=4 C=2: 8 beats pass, the 9th is held off
        beat_cnt = 0;
        d = done_cnt;
        e = err_cnt;
        exp_cmp.push_back(8'd2);
        load_beats(9, 8);
        send_job(4, 2);
        @(negedge ap_clk);
        check("nom_cmp_latency", BW'(M_AXIS_CMP_VEC_NO_tvalid), BW'(1));
        check("nom_busy", BW'(o_Busy), BW'(1));
        wait_beats(8, 200);
        repeat (3) @(negedge ap_clk);
        check("nom_gate_closed", BW'(S_AXIS_SRC_tready), BW'(0));
        check("nom_ninth_held", BW'(src_q.size()), BW'(1));
        check("nom_beats", BW'(beat_cnt), BW'(8));
        push_pairs(5);
        wait_done(d, 200);
        check("nom_pair_count", BW'(o_PairCount), BW'(5));
        check("nom_done_latency", BW'(done_cyc - last_pair_cyc), BW'(1));
        check("nom_no_error", BW'(err_cnt), BW'(e));
        src_q.delete();

        // Backpressure on data, CMP and result readies
        bp = 1'b1;
        beat_cnt = 0;
        d = done_cnt;
        exp_cmp.push_back(8'd2);
        load_beats(9, 8);
        send_job(4, 2);
        wait_beats(8, 500);
        repeat (4) @(negedge ap_clk);
        check("bp_gate_closed", BW'(S_AXIS_SRC_tready), BW'(0));
        check("bp_beats", BW'(beat_cnt), BW'(8));
        push_pairs(3);
        wait_done(d, 300);
        check("bp_pair_count", BW'(o_PairCount), BW'(3));
        check("bp_cmp_consumed", BW'(exp_cmp.size()), BW'(0));
        bp = 1'b0;
        src_q.delete();

        // Rejected descriptors
        for (int k = 0; k < 2; k++) begin
            d = done_cnt;
            e = err_cnt;
            h = cmp_hs_cnt;
            beat_cnt = 0;
            load_beats(1, 0);
            send_job(rej_n[k], rej_c[k]);
            @(negedge ap_clk);
            check("rej_done", BW'(o_Done), BW'(1));
            check("rej_error", BW'(o_Error), BW'(1));
            check("rej_cmp_tvalid", BW'(M_AXIS_CMP_VEC_NO_tvalid), BW'(0));
            check("rej_src_tready", BW'(S_AXIS_SRC_tready), BW'(0));
            @(negedge ap_clk);
            check("rej_done_pulse", BW'(o_Done), BW'(0));
            check("rej_idle", BW'(o_Busy), BW'(0));
            check("rej_no_cmp", BW'(cmp_hs_cnt), BW'(h));
            check("rej_no_beats", BW'(beat_cnt), BW'(0));
            check("rej_latency", BW'(done_cyc - acc_cyc), BW'(1));
            src_q.delete();
        end

        // Early tlast while still streaming N=2 C=1
        beat_cnt = 0;
        d = done_cnt;
        h = cmp_hs_cnt;
        exp_cmp.push_back(8'd1);
        send_job(2, 1);
        for (int t = 0; t < 50 && cmp_hs_cnt == h; t++) @(negedge ap_clk);
        check("early_cmp_hs", BW'(cmp_hs_cnt), BW'(h + 1));
        push_pairs(2);
        for (int t = 0; t < 50 && exp_res.size() != 0; t++) @(negedge ap_clk);
        repeat (2) @(negedge ap_clk);
        check("early_no_done_yet", BW'(done_cnt), BW'(d));
        load_beats(4, 4);
        wait_beats(4, 200);
        wait_done(d, 50);
        check("early_beats", BW'(beat_cnt), BW'(4));
        check("early_done_latency", BW'(done_cyc - last_beat_cyc), BW'(2));
        check("early_pair_count", BW'(o_PairCount), BW'(2));

        // Reset in the middle of streaming, then a fresh job
        beat_cnt = 0;
        exp_cmp.push_back(8'd2);
        load_beats(8, 8);
        send_job(4, 2);
        wait_beats(3, 200);
        @(posedge ap_clk);
        #1;
        ap_rstn = 1'b0;
        d = done_cnt;
        @(negedge ap_clk);
        check_idle_outputs("midrst");
        src_q.delete();
        exp_data.delete();
        exp_cmp.delete();
        pair_q.delete();
        exp_res.delete();
        repeat (2) @(negedge ap_clk);
        @(posedge ap_clk);
        #1;
        ap_rstn = 1'b1;
        repeat (3) @(negedge ap_clk);
        check("midrst_no_done", BW'(done_cnt), BW'(d));
        check("midrst_job_ready", BW'(S_AXIS_JOB_tready), BW'(1));

        beat_cnt = 0;
        d = done_cnt;
        e = err_cnt;
        exp_cmp.push_back(8'd1);
        load_beats(2, 2);
        send_job(1, 1);
        wait_beats(2, 200);
        push_pairs(1);
        wait_done(d, 200);
        check("post_beats", BW'(beat_cnt), BW'(2));
        check("post_pair_count", BW'(o_PairCount), BW'(1));
        check("post_no_error", BW'(err_cnt), BW'(e));
        check("post_scoreboard_empty", BW'(exp_data.size() + exp_res.size() + exp_cmp.size()), BW'(0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
